// File: rtl/pwm_breath_pkg.sv
// Shared types for the multi-channel PWM breathing engine.
// Ramp modes and triangle direction.
package pwm_breath_pkg;

  typedef enum logic [1:0] {
    MODE_TRIANGLE,
    MODE_SAW_UP,
    MODE_SAW_DOWN,
    MODE_STATIC
  } mode_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

endpackage

// File: rtl/pwm_breathing_engine_if.sv
// Config and output bundle between register file and engine.
// master = register file side, slave = engine side.
interface pwm_breathing_engine_if
  import pwm_breath_pkg::*;
#(
  parameter int NumCh          = 4,
  parameter int Resolution     = 16,
  parameter int StepResolution = 8
);

  logic [NumCh-1:0]                en_i;
  logic [2*NumCh-1:0]              mode_i;
  logic [Resolution*NumCh-1:0]     bound_a_i;
  logic [Resolution*NumCh-1:0]     bound_b_i;
  logic [StepResolution*NumCh-1:0] step_i;
  logic [Resolution*NumCh-1:0]     update_period_i;
  logic [Resolution-1:0]           pwm_period_i;
  logic [Resolution*NumCh-1:0]     duty_o;
  logic [NumCh-1:0]                pwm_o;
  logic [NumCh-1:0]                cycle_done_o;

  modport master (
    output en_i, mode_i,
    output bound_a_i, bound_b_i,
    output step_i, update_period_i,
    output pwm_period_i,
    input  duty_o, pwm_o, cycle_done_o
  );

  modport slave (
    input  en_i, mode_i,
    input  bound_a_i, bound_b_i,
    input  step_i, update_period_i,
    input  pwm_period_i,
    output duty_o, pwm_o, cycle_done_o
  );

endinterface

// File: rtl/pwm_breath_channel.sv
// One breathing channel: bound sort, restart detect, prescaler,
// duty/direction FSM, shadow duty and PWM comparator.
module pwm_breath_channel
  import pwm_breath_pkg::*;
#(
  parameter int Resolution     = 16,
  parameter int StepResolution = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [1:0]                mode_i,
  input  logic [Resolution-1:0]     bound_a_i,
  input  logic [Resolution-1:0]     bound_b_i,
  input  logic [StepResolution-1:0] step_i,
  input  logic [Resolution-1:0]     update_period_i,
  input  logic [Resolution-1:0]     cnt_i,
  input  logic                      wrap_i,
  output logic [Resolution-1:0]     duty_o,
  output logic                      pwm_o,
  output logic                      done_o
);

  localparam int W = Resolution + 1;

  mode_e                 mode, mode_q;
  dir_e                  dir_q, dir_d;
  logic [Resolution-1:0] lo, hi, lo_q, hi_q;
  logic [Resolution-1:0] presc_q, presc_d;
  logic [Resolution-1:0] duty_q, duty_d;
  logic [Resolution-1:0] shadow_q, shadow_d;
  logic [Resolution-1:0] step_r;
  logic [W-1:0]          step_x, duty_x, lo_x, hi_x;
  logic [W-1:0]          up_sum, lo_sum;
  logic                  pwm_q, pwm_d, done_q, done_d;
  logic                  restart, tick, hold;

  assign mode   = mode_e'(mode_i);
  assign lo     = (bound_a_i < bound_b_i) ? bound_a_i : bound_b_i;
  assign hi     = (bound_a_i < bound_b_i) ? bound_b_i : bound_a_i;
  assign step_r = Resolution'(step_i);
  assign step_x = W'(step_i);
  assign duty_x = {1'b0, duty_q};
  assign lo_x   = {1'b0, lo};
  assign hi_x   = {1'b0, hi};
  assign up_sum = duty_x + step_x;
  assign lo_sum = lo_x + step_x;

  assign restart = {lo, hi, mode} != {lo_q, hi_q, mode_q};
  assign tick    = presc_q >= update_period_i;
  assign hold    = (step_i == '0) || (lo == hi);

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    duty_d   = duty_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    shadow_d = wrap_i ? duty_q : shadow_q;
    pwm_d    = en_i && (cnt_i < shadow_q);
    if (!en_i || restart) begin
      presc_d = '0;
      duty_d  = lo;
      dir_d   = DIR_UP;
    end else if (mode == MODE_STATIC) begin
      duty_d = hi;
    end else if (tick && !hold) begin
      unique case (1'b1)
        mode == MODE_TRIANGLE && dir_q == DIR_UP: begin
          if (up_sum >= hi_x) begin
            duty_d = hi;
            dir_d  = DIR_DOWN;
            done_d = 1'b1;
          end else begin
            duty_d = duty_q + step_r;
          end
        end
        mode == MODE_TRIANGLE && dir_q == DIR_DOWN: begin
          if (duty_x <= lo_sum) begin
            duty_d = lo;
            dir_d  = DIR_UP;
            done_d = 1'b1;
          end else begin
            duty_d = duty_q - step_r;
          end
        end
        mode == MODE_SAW_UP: begin
          if (up_sum > hi_x) begin
            duty_d = lo;
            done_d = 1'b1;
          end else begin
            duty_d = duty_q + step_r;
          end
        end
        mode == MODE_SAW_DOWN: begin
          if (duty_x < lo_sum) begin
            duty_d = hi;
            done_d = 1'b1;
          end else begin
            duty_d = duty_q - step_r;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lo_q     <= '0;
      hi_q     <= '0;
      mode_q   <= MODE_TRIANGLE;
      presc_q  <= '0;
      duty_q   <= '0;
      dir_q    <= DIR_UP;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      lo_q     <= lo;
      hi_q     <= hi;
      mode_q   <= mode;
      presc_q  <= presc_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      done_q   <= done_d;
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = pwm_q;
  assign done_o = done_q;

endmodule

// File: rtl/pwm_breathing_engine.sv
// Multi-channel breathing PWM: shared base counter feeding
// NumCh independent ramp channels.
module pwm_breathing_engine
  import pwm_breath_pkg::*;
#(
  parameter int NumCh          = 4,
  parameter int Resolution     = 16,
  parameter int StepResolution = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  pwm_breathing_engine_if.slave bus
);

  logic [Resolution-1:0] cnt_q, cnt_d;
  logic                  wrap;

  // >= rather than == so a shrinking period never stalls the counter
  assign wrap  = cnt_q >= bus.pwm_period_i;
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    pwm_breath_channel #(
      .Resolution     (Resolution),
      .StepResolution (StepResolution)
    ) u_ch (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .en_i            (bus.en_i[c]),
      .mode_i          (bus.mode_i[2*c +: 2]),
      .bound_a_i       (bus.bound_a_i[c*Resolution +: Resolution]),
      .bound_b_i       (bus.bound_b_i[c*Resolution +: Resolution]),
      .step_i          (bus.step_i[c*StepResolution +: StepResolution]),
      .update_period_i (bus.update_period_i[c*Resolution +: Resolution]),
      .cnt_i           (cnt_q),
      .wrap_i          (wrap),
      .duty_o          (bus.duty_o[c*Resolution +: Resolution]),
      .pwm_o           (bus.pwm_o[c]),
      .done_o          (bus.cycle_done_o[c])
    );
  end

endmodule

// File: tb/tb_pwm_breathing_engine.sv
// Bench for pwm_breathing_engine: vector table, directed corner
// sequences and randomized traffic against an integer model.
module tb_pwm_breathing_engine;

  localparam int NC = 4;
  localparam int R  = 8;
  localparam int SR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_breathing_engine_if #(
    .NumCh(NC), .Resolution(R), .StepResolution(SR)
  ) bus ();

  pwm_breathing_engine #(
    .NumCh(NC), .Resolution(R), .StepResolution(SR)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt;
  int m_lo[NC], m_hi[NC], m_mode[NC];
  int m_presc[NC], m_duty[NC], m_dir[NC];
  int m_shadow[NC], m_pwm[NC], m_done[NC];

  typedef struct {
    int mode; int a; int b; int step;
    int duty; int done;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int md, int a, int b, int st,
                              int d, int dn);
    vec_t v;
    v.mode = md; v.a = a; v.b = b; v.step = st;
    v.duty = d; v.done = dn;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int duty(int c);
    return int'(bus.duty_o[c*R +: R]);
  endfunction

  task automatic set_ch(int c, int md, int a, int b, int st, int per);
    bus.mode_i[2*c +: 2]            = 2'(md);
    bus.bound_a_i[c*R +: R]         = R'(a);
    bus.bound_b_i[c*R +: R]         = R'(b);
    bus.step_i[c*SR +: SR]          = SR'(st);
    bus.update_period_i[c*R +: R]   = R'(per);
  endtask

  // Behavioural reference: next state from the current inputs.
  task automatic model_step();
    int pp, wrap, a, b, lo, hi, md, st, per, en, rs, tick;
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < NC; c++) begin
        m_lo[c] = 0; m_hi[c] = 0; m_mode[c] = 0;
        m_presc[c] = 0; m_duty[c] = 0; m_dir[c] = 0;
        m_shadow[c] = 0; m_pwm[c] = 0; m_done[c] = 0;
      end
      return;
    end
    pp = int'(bus.pwm_period_i);
    wrap = (m_cnt >= pp);
    for (int c = 0; c < NC; c++) begin
      a   = int'(bus.bound_a_i[c*R +: R]);
      b   = int'(bus.bound_b_i[c*R +: R]);
      md  = int'(bus.mode_i[2*c +: 2]);
      st  = int'(bus.step_i[c*SR +: SR]);
      per = int'(bus.update_period_i[c*R +: R]);
      en  = int'(bus.en_i[c]);
      lo  = (a < b) ? a : b;
      hi  = (a < b) ? b : a;
      rs  = (lo != m_lo[c]) || (hi != m_hi[c]) || (md != m_mode[c]);
      tick = en && (m_presc[c] == per);
      m_pwm[c] = en && (m_cnt < m_shadow[c]);
      if (wrap) m_shadow[c] = m_duty[c];
      m_done[c] = 0;
      if (!en || rs) begin
        m_duty[c] = lo; m_dir[c] = 0; m_presc[c] = 0;
      end else begin
        m_presc[c] = tick ? 0 : m_presc[c] + 1;
        if (md == 3) begin
          m_duty[c] = hi;
        end else if (tick && st != 0 && lo != hi) begin
          case (md)
            0: begin
              if (m_dir[c] == 0) begin
                if (m_duty[c] + st >= hi) begin
                  m_duty[c] = hi; m_dir[c] = 1; m_done[c] = 1;
                end else m_duty[c] += st;
              end else begin
                if (m_duty[c] <= lo + st) begin
                  m_duty[c] = lo; m_dir[c] = 0; m_done[c] = 1;
                end else m_duty[c] -= st;
              end
            end
            1: begin
              if (m_duty[c] + st > hi) begin
                m_duty[c] = lo; m_done[c] = 1;
              end else m_duty[c] += st;
            end
            default: begin
              if (m_duty[c] < lo + st) begin
                m_duty[c] = hi; m_done[c] = 1;
              end else m_duty[c] -= st;
            end
          endcase
        end
      end
      m_lo[c] = lo; m_hi[c] = hi; m_mode[c] = md;
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("model_duty%0d", c), duty(c), m_duty[c]);
      chk($sformatf("model_pwm%0d", c), int'(bus.pwm_o[c]), m_pwm[c]);
      chk($sformatf("model_done%0d", c),
          int'(bus.cycle_done_o[c]), m_done[c]);
    end
  endtask

  initial begin
    int hits, r, a;
    rst = 1'b1;
    bus.en_i = '0;
    bus.mode_i = '0;
    bus.bound_a_i = '0;
    bus.bound_b_i = '0;
    bus.step_i = '0;
    bus.update_period_i = '0;
    bus.pwm_period_i = 8'd9;
    cyc();
    cyc();
    for (int c = 0; c < NC; c++) begin
      chk("rst_duty", duty(c), 0);
      chk("rst_pwm", int'(bus.pwm_o[c]), 0);
      chk("rst_done", int'(bus.cycle_done_o[c]), 0);
    end
    rst = 1'b0;

    tbl.push_back(mk(0, 40, 10, 10, 10, 0));
    tbl.push_back(mk(0, 40, 10, 10, 20, 0));
    tbl.push_back(mk(0, 40, 10, 10, 30, 0));
    tbl.push_back(mk(0, 40, 10, 10, 40, 1));
    tbl.push_back(mk(0, 40, 10, 10, 30, 0));
    tbl.push_back(mk(0, 40, 10, 10, 20, 0));
    tbl.push_back(mk(0, 40, 10, 10, 10, 1));
    tbl.push_back(mk(0, 40, 10, 10, 20, 0));
    tbl.push_back(mk(0, 40, 10, 10, 30, 0));
    tbl.push_back(mk(0, 40, 0, 10, 0, 0));
    tbl.push_back(mk(0, 40, 0, 10, 10, 0));
    tbl.push_back(mk(1, 200, 255, 100, 200, 0));
    tbl.push_back(mk(1, 200, 255, 100, 200, 1));
    tbl.push_back(mk(1, 200, 255, 100, 200, 1));
    tbl.push_back(mk(0, 200, 255, 100, 200, 0));
    tbl.push_back(mk(0, 200, 255, 100, 255, 1));
    tbl.push_back(mk(0, 200, 255, 100, 200, 1));
    tbl.push_back(mk(0, 200, 255, 100, 255, 1));
    tbl.push_back(mk(2, 255, 200, 100, 200, 0));
    tbl.push_back(mk(2, 255, 200, 100, 255, 1));
    tbl.push_back(mk(2, 255, 200, 100, 255, 1));
    tbl.push_back(mk(3, 200, 255, 100, 200, 0));
    tbl.push_back(mk(3, 200, 255, 100, 255, 0));
    tbl.push_back(mk(3, 200, 255, 100, 255, 0));
    tbl.push_back(mk(0, 10, 40, 0, 10, 0));
    tbl.push_back(mk(0, 10, 40, 0, 10, 0));
    tbl.push_back(mk(0, 7, 7, 5, 7, 0));
    tbl.push_back(mk(0, 7, 7, 5, 7, 0));

    bus.en_i[0] = 1'b1;
    foreach (tbl[i]) begin
      set_ch(0, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].step, 0);
      cyc();
      chk($sformatf("tbl%0d_duty", i), duty(0), tbl[i].duty);
      chk($sformatf("tbl%0d_done", i),
          int'(bus.cycle_done_o[0]), tbl[i].done);
    end

    // static 3/10, then widen to 5 mid-period
    bus.en_i[2] = 1'b1;
    set_ch(2, 3, 3, 3, 1, 0);
    repeat (30) cyc();
    for (int i = 0; i < 20 && m_cnt != 1; i++) cyc();
    chk("align_cnt", m_cnt, 1);
    set_ch(2, 3, 5, 5, 1, 0);
    hits = 0;
    repeat (10) begin cyc(); hits += int'(bus.pwm_o[2]); end
    chk("pwm_old_width", hits, 3);
    hits = 0;
    repeat (10) begin cyc(); hits += int'(bus.pwm_o[2]); end
    chk("pwm_new_width", hits, 5);

    // enable gap with prescaler period 4
    set_ch(3, 0, 10, 200, 5, 4);
    bus.en_i[3] = 1'b1;
    repeat (12) cyc();
    bus.en_i[3] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("en_low_duty", duty(3), 10);
      if (i > 0) chk("en_low_pwm", int'(bus.pwm_o[3]), 0);
    end
    bus.en_i[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("en_rise_%0d", k), duty(3), (k < 5) ? 10 : 15);
    end

    // reset mid-ramp across all modes
    set_ch(0, 0, 30, 90, 7, 1);
    set_ch(1, 1, 20, 100, 9, 1);
    set_ch(2, 2, 150, 50, 11, 1);
    set_ch(3, 3, 40, 120, 3, 1);
    bus.en_i = '1;
    repeat (15) cyc();
    rst = 1'b1;
    cyc();
    for (int c = 0; c < NC; c++) begin
      chk("mid_rst_duty", duty(c), 0);
      chk("mid_rst_pwm", int'(bus.pwm_o[c]), 0);
      chk("mid_rst_done", int'(bus.cycle_done_o[c]), 0);
    end
    rst = 1'b0;
    cyc();
    chk("reload_lo0", duty(0), 30);
    chk("reload_lo1", duty(1), 20);
    chk("reload_lo2", duty(2), 50);
    chk("reload_lo3", duty(3), 40);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0)
        bus.pwm_period_i = R'($urandom_range(0, 40));
      for (int c = 0; c < NC; c++) begin
        r = $urandom_range(0, 79);
        if (r <= 1) begin
          a = $urandom_range(0, 255);
          bus.mode_i[2*c +: 2] = 2'($urandom_range(0, 3));
          bus.bound_a_i[c*R +: R] = R'(a);
          bus.bound_b_i[c*R +: R] = ($urandom_range(0, 7) == 0) ?
              R'(a) : R'($urandom_range(0, 255));
          bus.step_i[c*SR +: SR] = ($urandom_range(0, 3) == 0) ?
              '0 : SR'($urandom_range(1, 120));
          if (r == 0) begin
            bus.update_period_i[c*R +: R] = R'($urandom_range(0, 3));
            bus.en_i[c] = 1'b0;
          end
        end else if ($urandom_range(0, 59) == 0) begin
          bus.en_i[c] = ~bus.en_i[c];
        end
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
